core_seq: RTL

Parametrised multi-cycle sequencer for the RV32I core: it replaces the free-running fixed state ring with a handshake-aware control FSM. It owns the PC, instruction latch, next-PC selection, load/store byte-lane formatting and trap entry. It sits between instruction/data memory and the existing decode, ALU and register-file blocks. Memories may insert any number of wait states through REQ/ACK.

---
 rtl/core_seq.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/core_seq.sv
// Multi-cycle RV32I sequencer: owns PC, instruction latch, next-PC selection,
// load/store lane formatting and trap entry, with REQ/ACK on both memory buses.
module core_seq #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        I_MEM_REQ,
  output logic [31:0] I_MEM_ADDR,
  input  logic        I_MEM_ACK,
  input  logic [31:0] I_MEM_IN,
  output logic        D_MEM_REQ,
  output logic        D_MEM_WE,
  output logic [3:0]  D_MEM_BE,
  output logic [31:0] D_MEM_ADDR,
  output logic [31:0] D_MEM_DATA,
  input  logic        D_MEM_ACK,
  input  logic [31:0] D_MEM_IN,
  output logic [31:0] INST,
  input  logic        IS_LOAD,
  input  logic        IS_STORE,
  input  logic        IS_BRANCH,
  input  logic        IS_JAL,
  input  logic        IS_JALR,
  input  logic        N_INST,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] IMM,
  input  logic [31:0] RS1,
  input  logic [31:0] RS2,
  input  logic [31:0] ALU_RESULT,
  output logic [31:0] PC,
  output logic        REG_WE,
  output logic [31:0] REG_WDATA,
  output logic        RETIRED,
  output logic        TRAP,
  output logic [1:0]  TRAP_CAUSE,
  output logic [31:0] EPC,
  output logic [2:0]  DBG_STATE
);

  // Handshake: a bus transfer completes in the cycle where REQ=1 and ACK=1.
  // REQ and all qualifiers are registered and held stable until that cycle;
  // ACK seen while REQ=0 is ignored. A reset may abandon a pending request.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] next_pc_q;
  logic [31:0] alu_q;
  logic        is_load_q;
  logic        is_store_q;
  logic        link_q;
  logic        wb_en_q;
  logic [2:0]  funct3_q;

  logic [31:0] target;
  logic        addr_misaligned;
  logic [3:0]  lane_be;
  logic [31:0] store_data;
  logic [31:0] lane_word;
  logic [31:0] load_data;
  logic [31:0] wb_data;
  logic        mem_op;
  logic        mem_done;

  assign PC         = pc_q;
  assign I_MEM_ADDR = pc_q;
  assign DBG_STATE  = state;

  always_comb begin
    target = pc_q + 32'd4;
    if (IS_JALR)
      target = (RS1 + IMM) & ~32'd1;
    else if (IS_JAL || (IS_BRANCH && ALU_RESULT[0]))
      target = pc_q + IMM;
  end

  always_comb begin
    addr_misaligned = 1'b0;
    lane_be         = 4'b1111;
    store_data      = RS2;
    case (FUNCT3[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << ALU_RESULT[1:0];
        store_data = {4{RS2[7:0]}};
      end
      2'b01: begin
        addr_misaligned = ALU_RESULT[0];
        lane_be         = 4'b0011 << ALU_RESULT[1:0];
        store_data      = {2{RS2[15:0]}};
      end
      2'b10: addr_misaligned = |ALU_RESULT[1:0];
      default: ;
    endcase
  end

  // Load lane select uses the registered address and width, not decoder inputs.
  always_comb begin
    lane_word = D_MEM_IN >> {D_MEM_ADDR[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b100:  load_data = {24'd0, lane_word[7:0]};
      3'b101:  load_data = {16'd0, lane_word[15:0]};
      default: load_data = D_MEM_IN;
    endcase
  end

  always_comb begin
    mem_op   = is_load_q || is_store_q;
    mem_done = !mem_op || (D_MEM_REQ && D_MEM_ACK);
    if (link_q)
      wb_data = pc_q + 32'd4;
    else if (is_load_q)
      wb_data = load_data;
    else
      wb_data = alu_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      pc_q       <= RESET_VECTOR;
      next_pc_q  <= RESET_VECTOR;
      alu_q      <= '0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      link_q     <= 1'b0;
      wb_en_q    <= 1'b0;
      funct3_q   <= '0;
      INST       <= '0;
      EPC        <= '0;
      TRAP_CAUSE <= '0;
      REG_WDATA  <= '0;
      I_MEM_REQ  <= 1'b0;
      D_MEM_REQ  <= 1'b0;
      D_MEM_WE   <= 1'b0;
      D_MEM_BE   <= '0;
      D_MEM_ADDR <= '0;
      D_MEM_DATA <= '0;
      REG_WE     <= 1'b0;
      RETIRED    <= 1'b0;
      TRAP       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          I_MEM_REQ <= 1'b1;
          state     <= S_FETCH;
        end

        S_FETCH: begin
          if (I_MEM_REQ && I_MEM_ACK) begin
            INST      <= I_MEM_IN;
            I_MEM_REQ <= 1'b0;
            state     <= S_DECODE;
          end
        end

        S_DECODE: state <= S_EXECUTE;

        S_EXECUTE: begin
          alu_q      <= ALU_RESULT;
          next_pc_q  <= target;
          is_load_q  <= IS_LOAD;
          is_store_q <= IS_STORE;
          link_q     <= IS_JAL || IS_JALR;
          wb_en_q    <= !(IS_STORE || IS_BRANCH);
          funct3_q   <= FUNCT3;
          if (N_INST || (target[1:0] != 2'b00) ||
              ((IS_LOAD || IS_STORE) && addr_misaligned)) begin
            TRAP  <= 1'b1;
            EPC   <= pc_q;
            state <= S_TRAP;
            if (N_INST)
              TRAP_CAUSE <= 2'd0;
            else if (target[1:0] != 2'b00)
              TRAP_CAUSE <= 2'd1;
            else
              TRAP_CAUSE <= IS_STORE ? 2'd3 : 2'd2;
          end else begin
            if (IS_LOAD || IS_STORE) begin
              D_MEM_REQ  <= 1'b1;
              D_MEM_WE   <= IS_STORE;
              D_MEM_BE   <= lane_be;
              D_MEM_ADDR <= ALU_RESULT;
              D_MEM_DATA <= store_data;
            end
            state <= S_MEMORY;
          end
        end

        S_MEMORY: begin
          if (mem_done) begin
            D_MEM_REQ <= 1'b0;
            D_MEM_WE  <= 1'b0;
            D_MEM_BE  <= '0;
            REG_WDATA <= wb_data;
            REG_WE    <= wb_en_q;
            RETIRED   <= 1'b1;
            state     <= S_WRITEBACK;
          end
        end

        S_WRITEBACK: begin
          REG_WE    <= 1'b0;
          RETIRED   <= 1'b0;
          pc_q      <= next_pc_q;
          I_MEM_REQ <= 1'b1;
          state     <= S_FETCH;
        end

        S_TRAP: begin
          TRAP      <= 1'b0;
          pc_q      <= TRAP_VECTOR;
          I_MEM_REQ <= 1'b1;
          state     <= S_FETCH;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
